// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the instruction-fetch sequencing controller:
// PC mux selects, FSM states and the redirect-source priority helper.
package fetch_ctrl_pkg;

  localparam logic [1:0] PCSEL_BRANCH = 2'b00;
  localparam logic [1:0] PCSEL_JAL    = 2'b01;
  localparam logic [1:0] PCSEL_JALR   = 2'b10;
  localparam logic [1:0] PCSEL_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  // Branch outranks JAL, which outranks JALR; no source selects PC+4.
  function automatic logic [1:0] redirect_sel(input logic branch,
                                              input logic jal,
                                              input logic jalr);
    if (branch)    return PCSEL_BRANCH;
    else if (jal)  return PCSEL_JAL;
    else if (jalr) return PCSEL_JALR;
    else           return PCSEL_SEQ;
  endfunction

endpackage

// File: rtl/fetch_ctrl_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear)
      count <= '0;
    else if (inc && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: arbitrates redirects against
// load-use stalls and imem wait states, parking a redirect until the PC can move.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int         CNT_W        = 16,
  parameter logic [1:0] RESET_PC_SEL = 2'b11
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard_stall,
  input  logic             branch,
  input  logic             JAL,
  input  logic             JALR,
  input  logic [31:0]      branchAddr,
  input  logic [31:0]      JALAddr,
  input  logic [31:0]      JALRAddr,
  input  logic             imem_ready,
  output logic             imem_req,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic [31:0]      redirect_addr,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e      state, next_state;
  logic        redir;
  logic [1:0]  live_sel;
  logic [31:0] live_addr;
  logic        pending_valid;
  logic [31:0] pending_addr;
  logic        latch_redir;
  logic        replay;
  logic        apply_redir;
  logic        stall_inc;

  assign redir    = branch | JAL | JALR;
  assign live_sel = redirect_sel(branch, JAL, JALR);

  always_comb begin
    live_addr = '0;
    if (branch)    live_addr = branchAddr;
    else if (JAL)  live_addr = JALAddr;
    else if (JALR) live_addr = JALRAddr;
  end

  always_ff @(posedge clk) begin
    if (reset)
      state <= S_INIT;
    else
      state <= next_state;
  end

  // A stall alone keeps us in S_FETCH retrying; otherwise a missing
  // instruction parks us in S_WAIT until imem answers.
  always_comb begin
    next_state = state;
    case (state)
      S_INIT:  next_state = S_FETCH;
      S_FETCH: if (!imem_ready && (redir || !hazard_stall)) next_state = S_WAIT;
      S_WAIT:  if (imem_ready) next_state = S_FETCH;
      default: next_state = S_INIT;
    endcase
  end

  always_comb begin
    imem_req      = 1'b1;
    pc_write      = 1'b0;
    pc_sel        = PCSEL_SEQ;
    redirect_addr = '0;
    ifid_write    = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    latch_redir   = 1'b0;
    replay        = 1'b0;
    apply_redir   = 1'b0;
    if (reset || (state == S_INIT)) begin
      imem_req   = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      pc_sel     = RESET_PC_SEL;
    end else begin
      // A parked redirect owns the mux; live sources behind it are wrong-path.
      if (pending_valid) begin
        pc_sel        = PCSEL_BRANCH;
        redirect_addr = pending_addr;
      end else if (redir) begin
        pc_sel        = live_sel;
        redirect_addr = live_addr;
      end
      if (state == S_FETCH) begin
        if (redir) begin
          ifid_write = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (imem_ready) begin
            pc_write    = 1'b1;
            apply_redir = 1'b1;
          end else begin
            latch_redir = 1'b1;
          end
        end else if (hazard_stall) begin
          idex_flush = 1'b1;
        end else begin
          ifid_write = 1'b1;
          if (imem_ready) pc_write   = 1'b1;
          else            ifid_flush = 1'b1;
        end
      end else begin
        ifid_write = 1'b1;
        ifid_flush = 1'b1;
        if (pending_valid) begin
          if (imem_ready) begin
            pc_write    = 1'b1;
            replay      = 1'b1;
            apply_redir = 1'b1;
          end
        end else if (redir) begin
          idex_flush = 1'b1;
          if (imem_ready) begin
            pc_write    = 1'b1;
            apply_redir = 1'b1;
          end else begin
            latch_redir = 1'b1;
          end
        end else if (imem_ready) begin
          pc_write   = 1'b1;
          ifid_flush = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_valid <= 1'b0;
      pending_addr  <= '0;
    end else if (latch_redir) begin
      pending_valid <= 1'b1;
      pending_addr  <= live_addr;
    end else if (replay) begin
      pending_valid <= 1'b0;
    end
  end

  assign stall_inc = !reset && (state != S_INIT) && !pc_write;

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (apply_redir),
    .count (redirect_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_fetch_ctrl;

  localparam int CNT_W = 5;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             hazard_stall;
  logic             branch, JAL, JALR;
  logic [31:0]      branchAddr, JALAddr, JALRAddr;
  logic             imem_ready;
  logic             imem_req, pc_write, ifid_write, ifid_flush, idex_flush;
  logic [1:0]       pc_sel;
  logic [31:0]      redirect_addr;
  logic [CNT_W-1:0] redirect_cnt, stall_cnt;

  fetch_ctrl #(.CNT_W(CNT_W), .RESET_PC_SEL(2'b11)) dut (
    .clk           (clk),
    .reset         (reset),
    .hazard_stall  (hazard_stall),
    .branch        (branch),
    .JAL           (JAL),
    .JALR          (JALR),
    .branchAddr    (branchAddr),
    .JALAddr       (JALAddr),
    .JALRAddr      (JALRAddr),
    .imem_ready    (imem_ready),
    .imem_req      (imem_req),
    .pc_write      (pc_write),
    .pc_sel        (pc_sel),
    .redirect_addr (redirect_addr),
    .ifid_write    (ifid_write),
    .ifid_flush    (ifid_flush),
    .idex_flush    (idex_flush),
    .redirect_cnt  (redirect_cnt),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state: just-out-of-reset flag, waiting-on-imem flag,
  // parked redirect targets, and plain integer event counts.
  bit          m_init;
  bit          m_wait;
  logic [31:0] m_pend[$];
  int          m_rc;
  int          m_sc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
  endtask

  task automatic drive(input bit rst, input bit hs, input bit br, input bit j, input bit jr,
                       input bit rdy, input logic [31:0] ba, input logic [31:0] ja,
                       input logic [31:0] jra);
    reset = rst; hazard_stall = hs; branch = br; JAL = j; JALR = jr;
    imem_ready = rdy; branchAddr = ba; JALAddr = ja; JALRAddr = jra;
  endtask

  task automatic step();
    logic        e_req, e_pw, e_iw, e_iff, e_idf;
    logic [1:0]  e_sel;
    logic [31:0] e_addr;
    bit          redir, pendv, applied;
    logic [1:0]  lsel;
    logic [31:0] laddr;
    @(negedge clk);
    redir = branch || JAL || JALR;
    lsel  = branch ? 2'd0 : JAL ? 2'd1 : JALR ? 2'd2 : 2'd3;
    laddr = branch ? branchAddr : JAL ? JALAddr : JALR ? JALRAddr : 32'd0;
    pendv = (m_pend.size() != 0);
    e_req = 1; e_pw = 0; e_iw = 0; e_iff = 0; e_idf = 0; e_sel = 2'd3; e_addr = 0;
    applied = 0;
    if (reset || m_init) begin
      e_req = 0; e_iff = 1; e_idf = 1;
    end else begin
      e_addr = pendv ? m_pend[0] : laddr;
      e_sel  = pendv ? 2'd0 : lsel;
      if (!m_wait) begin
        if (redir) begin
          e_iw = 1; e_iff = 1; e_idf = 1;
          if (imem_ready) begin e_pw = 1; applied = 1; end
          else begin m_pend.push_back(laddr); m_wait = 1; end
        end else if (hazard_stall) begin
          e_idf = 1;
        end else if (imem_ready) begin
          e_pw = 1; e_iw = 1;
        end else begin
          e_iw = 1; e_iff = 1; m_wait = 1;
        end
      end else begin
        e_iw = 1; e_iff = 1;
        if (pendv) begin
          if (imem_ready) begin
            e_pw = 1; applied = 1; void'(m_pend.pop_front()); m_wait = 0;
          end
        end else if (redir) begin
          e_idf = 1;
          if (imem_ready) begin e_pw = 1; applied = 1; m_wait = 0; end
          else m_pend.push_back(laddr);
        end else if (imem_ready) begin
          e_pw = 1; e_iff = 0; m_wait = 0;
        end
      end
    end
    check("imem_req",      imem_req,      e_req);
    check("pc_write",      pc_write,      e_pw);
    check("pc_sel",        pc_sel,        e_sel);
    check("redirect_addr", redirect_addr, e_addr);
    check("ifid_write",    ifid_write,    e_iw);
    check("ifid_flush",    ifid_flush,    e_iff);
    check("idex_flush",    idex_flush,    e_idf);
    check("redirect_cnt",  redirect_cnt,  m_rc);
    check("stall_cnt",     stall_cnt,     m_sc);
    if (reset) begin
      m_pend.delete(); m_wait = 0; m_init = 1; m_rc = 0; m_sc = 0;
    end else begin
      if (!m_init && !e_pw && m_sc < MAXC) m_sc++;
      if (applied && m_rc < MAXC) m_rc++;
      m_init = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    m_init = 1; m_wait = 0; m_rc = 0; m_sc = 0; m_pend.delete();

    repeat (3) step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step();
    step();

    drive(0, 0, 1, 1, 0, 1, 32'h40, 32'h80, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step();

    drive(0, 1, 0, 0, 0, 1, 0, 0, 0);
    repeat (2) step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step();

    drive(0, 0, 0, 0, 1, 0, 0, 0, 32'h32);
    step();
    drive(0, 0, 1, 0, 0, 0, 32'h99, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step();
    step();

    drive(0, 1, 0, 1, 0, 1, 0, 32'h8, 0);
    step();

    drive(0, 1, 0, 0, 0, 1, 0, 0, 0);
    repeat (MAXC + 8) step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step();

    drive(0, 0, 0, 1, 0, 0, 0, 32'h1234, 0);
    step();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
    step();
    step();

    for (int i = 0; i < 800; i++) begin
      drive(($urandom % 64) == 0,
            ($urandom % 5) == 0,
            ($urandom % 9) == 0,
            ($urandom % 9) == 0,
            ($urandom % 9) == 0,
            ($urandom % 10) < 7,
            $urandom, $urandom, $urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencing controller for the instruction-fetch stage. It owns the PC write enable, PC mux select, IF/ID write/flush, ID/EX flush and the instruction-memory request.
- Arbitrates redirect sources (branch, JAL, JALR) against load-use stalls and instruction-memory wait states.
- Latches a redirect that arrives while the PC cannot advance, and replays it when the PC can.
- Sits between the hazard detection unit, the EX-stage redirect logic and the IF stage datapath.

Parameters:
- CNT_W, 16, width of the saturating performance counters.
- RESET_PC_SEL, 2'b11, PC mux select driven during reset and idle (sequential PC+4).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- hazard_stall  in  1  load-use stall request from hazard detection.
- branch  in  1  branch taken, resolved in EX.
- JAL  in  1  JAL redirect.
- JALR  in  1  JALR redirect.
- branchAddr  in  32  branch target.
- JALAddr  in  32  JAL target.
- JALRAddr  in  32  JALR target.
- imem_ready  in  1  instruction memory returns valid instruction this cycle.
- imem_req  out  1  fetch request at current PC.
- pc_write  out  1  PC load enable (1 = load); drives the IF stage pc_writeStall input.
- pc_sel  out  2  PC mux select: 00 branch/replay, 01 JAL, 10 JALR, 11 PC+4.
- redirect_addr  out  32  live selected target, or latched pending target; feeds the mux branch input during replay.
- ifid_write  out  1  IF/ID register load enable.
- ifid_flush  out  1  zero IF/ID (insert NOP).
- idex_flush  out  1  zero ID/EX control (insert bubble).
- redirect_cnt  out  CNT_W  number of redirects applied, saturating.
- stall_cnt  out  CNT_W  cycles with pc_write=0 outside reset, saturating.

Behaviour:
- **States:** S_INIT, S_FETCH, S_WAIT. Reset → S_INIT.
- **Reset values:** reset=1 forces pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, imem_req=0, pc_sel=RESET_PC_SEL, redirect_addr=0, pending_valid=0, pending_addr=0, both counters=0.
- **Reset mid-operation:** discards any pending redirect on the next clock edge.
- **S_INIT:** one cycle. Outputs equal the reset values. Go to S_FETCH.
- **Live redirect:** redir = branch|JAL|JALR.
  - Priority: branch > JAL > JALR.
  - pc_sel = 00/01/10 accordingly.
  - redirect_addr = the matching target.
  - When no redirect is live and none is pending, redirect_addr = 0.
- **S_FETCH:**
  - imem_req=1 in all cases.
  - redir & imem_ready: pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1, redirect_cnt+1. Stay S_FETCH. A redirect overrides hazard_stall in the same cycle.
  - redir & !imem_ready: latch pending_addr=redirect_addr, pending_valid=1, pc_write=0, ifid_flush=1, idex_flush=1. Go S_WAIT.
  - !redir & hazard_stall: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0. Stay S_FETCH. hazard_stall alone takes precedence over imem_ready=0, and the fetch is retried next cycle.
  - !redir & !hazard_stall & imem_ready: pc_write=1, pc_sel=11, ifid_write=1, no flushes.
  - !redir & !imem_ready: pc_write=0, ifid_write=1, ifid_flush=1. Go S_WAIT.
- **S_WAIT:**
  - imem_req=1. pc_write=0 and ifid_flush=1 until imem_ready.
  - Live redirect while pending_valid=1: ignored. It comes from a wrong-path instruction.
  - Live redirect while pending_valid=0: latched as in S_FETCH, with idex_flush=1.
  - imem_ready & pending_valid: pc_write=1, pc_sel=00, redirect_addr=pending_addr, ifid_flush=1, pending_valid=0, redirect_cnt+1. Go S_FETCH.
  - imem_ready & !pending_valid: pc_write=1, pc_sel=11, ifid_write=1, ifid_flush=0. Go S_FETCH.
  - hazard_stall in S_WAIT: ignored. IF/ID already holds a bubble.
- **Counters:** increment on the clock edge after the qualifying cycle. They saturate at all-ones and never wrap.
- **Output style:** all outputs except the counters and pending registers are combinational from state and inputs. There is no latency beyond the FSM registers.

Decomposition:
- Shared package holds:
  - PC select encodings: PCSEL_BRANCH=2'b00, PCSEL_JAL=2'b01, PCSEL_JALR=2'b10, PCSEL_SEQ=2'b11.
  - FSM state encoding.
- One sub-module: sat_counter (parameter W; inputs inc, clear), instantiated twice for the counters.

Test Plan:
- Reset 3 cycles, then release with imem_ready=1 → first cycle pc_write=0, ifid_flush=1; second cycle pc_write=1, pc_sel=11.
- branch=1 & JAL=1, branchAddr=0x40, JALAddr=0x80, imem_ready=1 → pc_sel=00, redirect_addr=0x40, ifid_flush=idex_flush=1, redirect_cnt=1.
- hazard_stall=1 for 2 cycles, no redirect → pc_write=0, ifid_write=0, idex_flush=1 both cycles; stall_cnt=2.
- JALR=1, JALRAddr=0x32 with imem_ready=0 for 3 cycles; branch pulses in cycle 2 → stays S_WAIT, branch ignored; on ready pc_sel=00, redirect_addr=0x32, pending cleared.
- hazard_stall=1 and JAL=1, JALAddr=0x8 in the same cycle → pc_write=1, pc_sel=01, both flushes asserted.
- Force stall_cnt to all-ones, then one more stall cycle → value unchanged; assert reset during S_WAIT with pending → next cycle pending_valid=0, state S_INIT.
